// File: rtl/date_hist_pkg.sv
// date_hist_pkg
// Shared definitions for the date history store: FSM state encoding, the
// default history depth, field offsets inside a packed 24-bit BCD date and
// a BCD digit check.
package date_hist_pkg;

    localparam int DEFAULT_DEPTH = 8;
    localparam int DATE_W        = 24;

    localparam int YEAR_LSB  = 16;
    localparam int MONTH_LSB = 8;
    localparam int DAY_LSB   = 0;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_WRITE   = 3'd1,
        ST_RD_ADDR = 3'd2,
        ST_RD_DATA = 3'd3,
        ST_DONE    = 3'd4,
        ST_ERR     = 3'd5
    } state_t;

    function automatic logic is_bcd(input logic [3:0] nib);
        return (nib <= 4'd9);
    endfunction

endpackage

// File: rtl/date_hist_ram.sv
// date_hist_ram
// DEPTH x DATE_W storage, one synchronous write port and one synchronous
// read port (one-cycle read latency). Contents are not reset.
// Ports:
//   clk      - system clock
//   we_i     - write enable
//   waddr_i  - write index
//   wdata_i  - write data
//   raddr_i  - read index, sampled every cycle
//   rdata_o  - registered read data
module date_hist_ram
    import date_hist_pkg::*;
#(
    parameter int DEPTH = DEFAULT_DEPTH,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              we_i,
    input  logic [AW-1:0]     waddr_i,
    input  logic [DATE_W-1:0] wdata_i,
    input  logic [AW-1:0]     raddr_i,
    output logic [DATE_W-1:0] rdata_o
);

    logic [DATE_W-1:0] mem_q [DEPTH];

    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
        rdata_o <= mem_q[raddr_i];
    end

endmodule

// File: rtl/date_history_store.sv
// date_history_store
// Circular history of BCD date snapshots with indexed read-back.
// A record stores the current date at the write pointer; a read returns
// entry rd_sel counted back from the most recent one, delivered on datePast
// with a one-cycle rdDone pulse.
// Ports:
//   clk, rst                - clock, synchronous active-high reset
//   year1..day0             - current date, BCD nibbles
//   rec_req, rd_req, clr_req- one-cycle requests (clear > record > read)
//   rd_sel                  - read index, 0 = most recent
//   datePast, rdDone        - read result and its valid pulse
//   rd_err, rec_err         - rejected read / rejected record pulses
//   count                   - number of valid entries
//   busy                    - FSM not idle
//
// state      | meaning
// IDLE       | sampling requests
// WRITE      | writing captured date, advancing pointer/count
// RD_ADDR    | RAM address presented
// RD_DATA    | RAM output registered into datePast
// DONE       | rdDone pulse
// ERR        | rd_err pulse
module date_history_store
    import date_hist_pkg::*;
#(
    parameter int DEPTH = DEFAULT_DEPTH,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [3:0]        year1,
    input  logic [3:0]        year0,
    input  logic [3:0]        month1,
    input  logic [3:0]        month0,
    input  logic [3:0]        day1,
    input  logic [3:0]        day0,
    input  logic              rec_req,
    input  logic              rd_req,
    input  logic [AW-1:0]     rd_sel,
    input  logic              clr_req,
    output logic [DATE_W-1:0] datePast,
    output logic              rdDone,
    output logic              rd_err,
    output logic              rec_err,
    output logic [AW:0]       count,
    output logic              busy
);

    localparam int CW = AW + 1;

    state_t            state_q;
    logic [AW-1:0]     wr_ptr_q;
    logic [AW-1:0]     rd_addr_q;
    logic [CW-1:0]     count_q;
    logic [DATE_W-1:0] wdata_q;
    logic [DATE_W-1:0] date_past_q;
    logic              rd_done_q;
    logic              rd_err_q;
    logic              rec_err_q;
    logic              busy_q;

    logic [DATE_W-1:0] cur_date;
    logic              cur_ok;
    logic [DATE_W-1:0] ram_rdata;

    assign cur_date = {year1, year0, month1, month0, day1, day0};
    assign cur_ok   = is_bcd(year1) && is_bcd(year0) && is_bcd(month1) &&
                      is_bcd(month0) && is_bcd(day1) && is_bcd(day0);

    date_hist_ram #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_ram (
        .clk     (clk),
        .we_i    (state_q == ST_WRITE),
        .waddr_i (wr_ptr_q),
        .wdata_i (wdata_q),
        .raddr_i (rd_addr_q),
        .rdata_o (ram_rdata)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            wr_ptr_q    <= '0;
            rd_addr_q   <= '0;
            count_q     <= '0;
            wdata_q     <= '0;
            date_past_q <= '0;
            rd_done_q   <= 1'b0;
            rd_err_q    <= 1'b0;
            rec_err_q   <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            // Pulse outputs default low; each is set only on the edge that
            // enters the cycle in which it should be visible.
            rd_done_q <= 1'b0;
            rd_err_q  <= 1'b0;
            rec_err_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (clr_req) begin
                        count_q  <= '0;
                        wr_ptr_q <= '0;
                    end else if (rec_req) begin
                        if (cur_ok) begin
                            wdata_q <= cur_date;
                            state_q <= ST_WRITE;
                            busy_q  <= 1'b1;
                        end else begin
                            rec_err_q <= 1'b1;
                        end
                    end else if (rd_req) begin
                        if ({1'b0, rd_sel} >= count_q) begin
                            rd_err_q <= 1'b1;
                            state_q  <= ST_ERR;
                        end else begin
                            // Newest entry sits one below the write pointer.
                            rd_addr_q <= wr_ptr_q - AW'(1) - rd_sel;
                            state_q   <= ST_RD_ADDR;
                        end
                        busy_q <= 1'b1;
                    end
                end
                ST_WRITE: begin
                    wr_ptr_q <= wr_ptr_q + AW'(1);
                    if (count_q != CW'(DEPTH)) begin
                        count_q <= count_q + CW'(1);
                    end
                    state_q <= ST_IDLE;
                    busy_q  <= 1'b0;
                end
                ST_RD_ADDR: begin
                    state_q <= ST_RD_DATA;
                end
                ST_RD_DATA: begin
                    date_past_q <= ram_rdata;
                    rd_done_q   <= 1'b1;
                    state_q     <= ST_DONE;
                end
                ST_DONE, ST_ERR: begin
                    state_q <= ST_IDLE;
                    busy_q  <= 1'b0;
                end
                default: begin
                    state_q <= ST_IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign datePast = date_past_q;
    assign rdDone   = rd_done_q;
    assign rd_err   = rd_err_q;
    assign rec_err  = rec_err_q;
    assign count    = count_q;
    assign busy     = busy_q;

endmodule

// File: doc/date_history_store.md
# date_history_store

Records snapshots of the current calendar date into a small circular history buffer and reads any stored entry back on request. It is the write/read-back end of the `datePast` / `rdDone` interface consumed by the date counter. It sits between the date counter outputs and the mode/key controller. A read delivers a 24-bit BCD date together with a one-cycle `rdDone` pulse that the date counter uses to reload its registers.

## Interface
- `DEPTH`, default 8: number of history entries; power of two, 2..16.
- `AW`, default log2(DEPTH): entry index width, derived.
- `clk  in  1`: system clock; all logic on rising edge.
- `rst  in  1`: synchronous, active-high reset.
- `year1, year0  in  4 each`: current year, BCD tens/units.
- `month1, month0  in  4 each`: current month, BCD.
- `day1, day0  in  4 each`: current day, BCD.
- `rec_req  in  1`: one-cycle request to store the current date.
- `rd_req  in  1`: one-cycle request to read entry `rd_sel`.
- `rd_sel  in  AW`: read index; 0 = most recent, 1 = one before, and so on.
- `clr_req  in  1`: one-cycle request to empty the history.
- `datePast  out  24`: {year BCD[23:16], month BCD[15:8], day BCD[7:0]} of the last successful read.
- `rdDone  out  1`: one-cycle pulse; `datePast` is valid in that cycle.
- `rd_err  out  1`: one-cycle pulse; the read index was ≥ `count`.
- `rec_err  out  1`: one-cycle pulse; the record was rejected because a nibble was non-BCD.
- `count  out  AW+1`: number of valid entries, 0..DEPTH.
- `busy  out  1`: high whenever the FSM is not in IDLE.

## Operation
- Reset values:
  - Outputs: `datePast`=0, `rdDone`=0, `rd_err`=0, `rec_err`=0, `count`=0, `busy`=0.
  - Internal: `wr_ptr`=0, state IDLE.
  - RAM contents are not cleared; they are unreachable while `count`=0.
- FSM states: IDLE, WRITE, RD_ADDR, RD_DATA, DONE, ERR.
- Request acceptance:
  - Requests are sampled only in IDLE.
  - Priority when several are high in the same cycle: `clr_req` > `rec_req` > `rd_req`. Lower-priority requests in that cycle are dropped.
  - Requests arriving while `busy`=1 are dropped, not queued.
- Clear: in IDLE, sets `count`=0 and `wr_ptr`=0 at the next edge and stays in IDLE. `datePast` is unchanged.
- Record:
  - Any input nibble > 9: pulse `rec_err` in the next cycle and stay in IDLE. Nothing is written.
  - Otherwise go to WRITE. WRITE writes {year1,year0,month1,month0,day1,day0} to RAM[`wr_ptr`], sets `wr_ptr` ← `wr_ptr`+1 (wraps modulo DEPTH), and sets `count` ← min(`count`+1, DEPTH). Then return to IDLE.
  - When full, the oldest entry is overwritten.
  - Date inputs are captured in the accept cycle; later changes are ignored.
- Read:
  - If `rd_sel` ≥ `count`: go to ERR, which pulses `rd_err` for one cycle, then return to IDLE. `datePast` is unchanged.
  - Otherwise latch addr = (`wr_ptr` − 1 − `rd_sel`) mod DEPTH, in AW-bit wrap arithmetic, and go to RD_ADDR.
  - RD_ADDR drives the RAM address; RD_DATA registers the RAM output into `datePast`; DONE asserts `rdDone`; then return to IDLE.
- `rdDone` and `rd_err` are never high together. `rec_err` never coincides with either.

## Timing
- Record accepted at edge N: RAM written at edge N+1. `count` updates at N+1; `busy` is high during the N+1 cycle only. A new request is accepted at edge N+2.
- Read accepted at edge N:
  - Sequence: RD_ADDR in cycle N+1, RD_DATA in N+2, DONE in N+3.
  - `datePast` is valid from cycle N+3 and held until the next successful read. `rdDone` is high in cycle N+3 only.
  - `busy` is high in cycles N+1..N+3. IDLE is reached again at N+4.
- Invalid read accepted at N: `rd_err` high in cycle N+1, IDLE at N+2.
- Clear accepted at N: `count`=0 in cycle N+1. `busy` stays low.
- Sync reset asserted in any state: at the next edge the FSM is in IDLE and all outputs are at their reset values. A pending `rdDone`/`rd_err` pulse is suppressed.
- RAM: synchronous read with 1-cycle latency, single write port.

## Structure
- Package `date_hist_pkg`:
  - state enum;
  - default `DEPTH`;
  - field offsets YEAR_LSB=16, MONTH_LSB=8, DAY_LSB=0;
  - BCD-check function (nibble ≤ 9).
- Sub-module `date_hist_ram`: DEPTH×24, one synchronous write port and one synchronous read port, no reset.
- The top level contains the FSM, pointers, counter and output registers.

## Test plan
- Record 2019-03-15, then read `rd_sel`=0 → `rdDone` pulses 3 cycles after accept with `datePast`=24'h190315; `count`=1.
- Record 9 dates D0..D8 with DEPTH=8 → `count`=8; `rd_sel`=7 returns D1 (D0 overwritten); `rd_sel`=0 returns D8.
- `count`=2, `rd_sel`=5 → `rd_err` high 1 cycle after accept; `rdDone` stays low; `datePast` is unchanged.
- `clr_req`, `rec_req` and `rd_req` all high in the same IDLE cycle → clear wins; `count`=0; no write, no `rdDone`.
- Record with `month0`=4'hA → `rec_err` pulse, `count` unchanged; `rec_req` issued during a read's `busy` window is ignored.
- Assert `rst` in the RD_DATA cycle → no `rdDone`; next cycle `count`=0 and `datePast`=0; a subsequent `rd_sel`=0 read gives `rd_err`.
